// File: rtl/cpu_pkg.sv
// Definitions shared by the fetch stage and its next-PC datapath:
// NPCOp encodings, fetch FSM states and the default reset PC.
package cpu_pkg;

  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  localparam logic [31:0] DEFAULT_PC_RESET = 32'h0000_3000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection for the fetch stage (plus4, branch, jump, jr).
// All arithmetic is modulo 2^32.
module npc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [1:0]  npc_op,
  output logic [31:0] npc,
  output logic [31:0] pc_plus4,
  output logic        jr_misalign
);

  logic [31:0] branch_offset;
  logic        unused_opcode_bits;

  assign pc_plus4      = pc + 32'd4;
  assign branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign jr_misalign   = |rs_data[1:0];

  // Opcode field only matters to decode; the target fields come from [25:0].
  assign unused_opcode_bits = ^instr[31:26];

  always_comb begin
    npc = pc_plus4;
    case (npc_op)
      NPC_PLUS4:  npc = pc_plus4;
      NPC_BRANCH: npc = pc_plus4 + branch_offset;
      NPC_JUMP:   npc = {pc_plus4[31:28], instr[25:0], 2'b00};
      NPC_JR:     npc = {rs_data[31:2], 2'b00};
      default:    npc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, fetches over req/gnt/rvalid and holds
// the instruction for decode until instr_ack commits the next PC.
module if_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] PC_RESET = DEFAULT_PC_RESET
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ack,
  input  logic [1:0]  npc_op,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        addr_err,
  output logic [1:0]  state
);

  // Handshakes: a request is accepted in the cycle imem_req and imem_gnt are
  // both high; read data is taken only in WAIT on imem_rvalid; instr is
  // consumed only in HOLD when instr_valid and instr_ack are both high.

  fetch_state_e state_q;
  logic [31:0]  npc;
  logic         jr_misalign;

  npc_calc u_npc_calc (
    .pc          (pc),
    .instr       (instr),
    .rs_data     (rs_data),
    .npc_op      (npc_op),
    .npc         (npc),
    .pc_plus4    (pc_plus4),
    .jr_misalign (jr_misalign)
  );

  assign imem_req  = (state_q == FETCH);
  assign imem_addr = pc;
  assign state     = state_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= FETCH;
      pc          <= PC_RESET;
      instr       <= 32'd0;
      instr_valid <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      case (state_q)
        // A simultaneous rvalid here belongs to no request of ours; only gnt counts.
        FETCH: begin
          if (imem_gnt) state_q <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ack) begin
            pc          <= npc;
            instr_valid <= 1'b0;
            state_q     <= FETCH;
            if (npc_op == NPC_JR && jr_misalign) addr_err <= 1'b1;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed NPCOp scenarios, randomised
// back-to-back fetches, stalls, mid-flight reset and gnt/rvalid collisions.
module tb_if_fetch;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ack = 1'b0;
  logic [1:0]  npc_op = 2'b00;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        addr_err;
  logic [1:0]  state;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];      // expected fetch addresses
  logic [31:0] instr_q[$];    // expected held instructions
  logic [31:0] pc_q[$];       // expected PC of held instruction
  logic [31:0] model_pc;
  logic        model_err;

  if_fetch dut (
    .clk         (clk),
    .rstn        (rstn),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ack   (instr_ack),
    .npc_op      (npc_op),
    .rs_data     (rs_data),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .addr_err    (addr_err),
    .state       (state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_npc(input logic [31:0] p, input logic [31:0] ins,
                                            input logic [1:0] op, input logic [31:0] rs);
    logic [31:0] p4;
    logic [31:0] off;
    p4  = p + 32'd4;
    off = {{14{ins[15]}}, ins[15:0], 2'b00};
    case (op)
      2'b00:   return p4;
      2'b01:   return p4 + off;
      2'b10:   return {p4[31:28], ins[25:0], 2'b00};
      default: return {rs[31:2], 2'b00};
    endcase
  endfunction

  task automatic apply_reset(input int cycles);
    rstn = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    instr_ack = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rstn = 1'b1;
    exp_q.delete();
    instr_q.delete();
    pc_q.delete();
    model_pc  = 32'h0000_3000;
    model_err = 1'b0;
    exp_q.push_back(32'h0000_3000);
  endtask

  // One full instruction: optional gnt stall, optional colliding rvalid in
  // FETCH, optional extra HOLD cycles with stray rvalid, then ack.
  task automatic do_fetch(input logic [31:0] rdata, input logic [1:0] op, input logic [31:0] rs,
                          input int stall, input int hold_extra, input bit gnt_rvalid);
    logic [31:0] exp_addr;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty: got no expected address, required one queued");
      exp_addr = 32'hxxxx_xxxx;
    end else begin
      exp_addr = exp_q.pop_front();
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
      failures++;
      $display("FAIL fetch_addr: got req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, exp_addr);
    end
    for (int i = 0; i < stall; i++) begin
      imem_gnt = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
        failures++;
        $display("FAIL fetch_stall: got req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, exp_addr);
      end
    end
    imem_gnt = 1'b1;
    if (gnt_rvalid) begin
      imem_rvalid = 1'b1;
      imem_rdata  = ~rdata;
    end
    @(posedge clk);
    #1;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL wait_state: got req=%b valid=%b required req=0 valid=0", imem_req, instr_valid);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = rdata;
    instr_q.push_back(rdata);
    pc_q.push_back(model_pc);
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    exp_instr = instr_q.pop_front();
    exp_pc    = pc_q.pop_front();
    for (int i = 0; i <= hold_extra; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr !== exp_instr || pc !== exp_pc ||
          pc_plus4 !== exp_pc + 32'd4 || imem_req !== 1'b0) begin
        failures++;
        $display("FAIL hold: got valid=%b instr=%h pc=%h pc4=%h req=%b required valid=1 instr=%h pc=%h pc4=%h req=0",
                 instr_valid, instr, pc, pc_plus4, imem_req, exp_instr, exp_pc, exp_pc + 32'd4);
      end
      if (i < hold_extra) begin
        imem_rvalid = 1'b1;
        imem_rdata  = $urandom;
        npc_op      = 2'($urandom_range(0, 3));
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
      end
    end
    instr_ack = 1'b1;
    npc_op    = op;
    rs_data   = rs;
    if (op == NPC_JR && rs[1:0] != 2'b00) model_err = 1'b1;
    model_pc = model_npc(model_pc, rdata, op, rs);
    exp_q.push_back(model_pc);
    @(posedge clk);
    #1;
    instr_ack = 1'b0;
    npc_op    = 2'($urandom_range(0, 3));
    rs_data   = $urandom;
    checks++;
    if (instr_valid !== 1'b0 || addr_err !== model_err || imem_req !== 1'b1) begin
      failures++;
      $display("FAIL after_ack: got valid=%b err=%b req=%b required valid=0 err=%b req=1",
               instr_valid, addr_err, imem_req, model_err);
    end
  endtask

  task automatic test_reset();
    apply_reset(2);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000 || instr_valid !== 1'b0 ||
        addr_err !== 1'b0 || instr !== 32'd0 || state !== 2'd0) begin
      failures++;
      $display("FAIL reset: got req=%b addr=%h valid=%b err=%b instr=%h state=%0d required 1 00003000 0 0 00000000 0",
               imem_req, imem_addr, instr_valid, addr_err, instr, state);
    end
  endtask

  task automatic test_sequential();
    do_fetch(32'h2008_0005, NPC_PLUS4, 32'd0, 0, 0, 1'b0);
    checks++;
    if (imem_addr !== 32'h0000_3004) begin
      failures++;
      $display("FAIL seq_next: got %h required 00003004", imem_addr);
    end
    do_fetch(32'h2009_0001, NPC_PLUS4, 32'd0, 1, 0, 1'b0);
  endtask

  task automatic test_branch();
    do_fetch(32'h1000_FFFE, NPC_BRANCH, 32'd0, 0, 1, 1'b0);
    checks++;
    if (imem_addr !== 32'h0000_3004) begin
      failures++;
      $display("FAIL branch_back: got %h required 00003004", imem_addr);
    end
    repeat (3) do_fetch(32'h0000_0000, NPC_PLUS4, 32'd0, 0, 0, 1'b0);
  endtask

  task automatic test_jump();
    do_fetch(32'h0800_0C10, NPC_JUMP, 32'd0, 0, 0, 1'b0);
    checks++;
    if (imem_addr !== 32'h0000_3040) begin
      failures++;
      $display("FAIL jump: got %h required 00003040", imem_addr);
    end
  endtask

  task automatic test_jr();
    do_fetch(32'h0060_0008, NPC_JR, 32'h0000_3011, 0, 0, 1'b0);
    checks++;
    if (imem_addr !== 32'h0000_3010 || addr_err !== 1'b1) begin
      failures++;
      $display("FAIL jr_misalign: got addr=%h err=%b required addr=00003010 err=1", imem_addr, addr_err);
    end
    do_fetch(32'h0000_0000, NPC_PLUS4, 32'd0, 0, 0, 1'b0);
    checks++;
    if (addr_err !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky: got %b required 1", addr_err);
    end
  endtask

  task automatic test_wrap();
    do_fetch(32'h03E0_0008, NPC_JR, 32'hFFFF_FFFC, 0, 0, 1'b0);
    do_fetch(32'h0000_0000, NPC_PLUS4, 32'd0, 0, 0, 1'b0);
    checks++;
    if (imem_addr !== 32'h0000_0000) begin
      failures++;
      $display("FAIL wrap: got %h required 00000000", imem_addr);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 12; n++) begin
      do_fetch($urandom, 2'($urandom_range(0, 3)), $urandom,
               $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
    end
  endtask

  task automatic test_stall_reset();
    apply_reset(1);
    checks++;
    if (addr_err !== 1'b0) begin
      failures++;
      $display("FAIL err_cleared: got %b required 0", addr_err);
    end
    // Acks and data outside HOLD must not move the PC.
    for (int i = 0; i < 3; i++) begin
      instr_ack = 1'b1;
      npc_op    = NPC_JUMP;
      imem_gnt  = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000) begin
        failures++;
        $display("FAIL stall_addr: got req=%b addr=%h required req=1 addr=00003000", imem_req, imem_addr);
      end
    end
    instr_ack = 1'b0;
    imem_gnt  = 1'b1;
    @(posedge clk);
    #1;
    imem_gnt = 1'b0;
    rstn     = 1'b0;
    @(posedge clk);
    #1;
    rstn        = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_3000) begin
      failures++;
      $display("FAIL stale_rvalid: got valid=%b req=%b addr=%h required valid=0 req=1 addr=00003000",
               instr_valid, imem_req, imem_addr);
    end
    do_fetch(32'h2008_0007, NPC_PLUS4, 32'd0, 0, 0, 1'b0);
  endtask

  task automatic test_simultaneous();
    do_fetch(32'h1234_5678, NPC_PLUS4, 32'd0, 0, 0, 1'b1);
    do_fetch(32'h0800_0100, NPC_JUMP, 32'd0, 2, 1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_jr();
    test_wrap();
    test_back_to_back();
    test_stall_reset();
    test_simultaneous();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
